// File: rtl/stack_ovf.sv
// stack_ovf: register-file stack for a J1-class core.
// The head (T) is a register. DEPTH tail cells sit behind it in a shift register,
// and cell 0 is next-on-stack (N). The block tracks a live depth count with
// empty/full flags, and sticky overflow/underflow flags that software can clear.
module stack_ovf #(
  parameter int unsigned          WIDTH = 16,
  parameter int unsigned          DEPTH = 18,
  parameter logic [WIDTH-1:0]     FILL  = 'h55aa,
  localparam int unsigned         DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       delta,
  input  logic [WIDTH-1:0] wd,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] rd2,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // Stack move encoding. Bit 0 set with bit 1 clear is a push.
  // Both bits set is a single pop. Bit 1 alone is a pop of two.
  typedef enum logic [1:0] {
    MV_HOLD = 2'b00,
    MV_PUSH = 2'b01,
    MV_POP2 = 2'b10,
    MV_POP  = 2'b11
  } move_e;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  move_e            move;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] cells_q [DEPTH];
  logic [WIDTH-1:0] cells_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             ovf_evt, udf_evt;

  assign move = move_e'(delta);

  // Data path: compute the next head and tail-cell contents for the requested move.
  always_comb begin
    head_d = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      cells_d[i] = cells_q[i];
    end
    unique case (move)
      MV_HOLD: begin
        if (we) head_d = wd;
      end
      MV_PUSH: begin
        // The old head becomes N. The deepest cell falls off the end.
        cells_d[0] = head_q;
        for (int i = 1; i < DEPTH; i++) begin
          cells_d[i] = cells_q[i-1];
        end
        if (we) head_d = wd;
      end
      MV_POP: begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          cells_d[i] = cells_q[i+1];
        end
        cells_d[DEPTH-1] = FILL;
        head_d = we ? wd : cells_q[0];
      end
      MV_POP2: begin
        for (int i = 0; i < DEPTH - 2; i++) begin
          cells_d[i] = cells_q[i+2];
        end
        cells_d[DEPTH-2] = FILL;
        cells_d[DEPTH-1] = FILL;
        head_d = we ? wd : cells_q[1];
      end
      default: begin
        head_d = head_q;
      end
    endcase
  end

  // Control path: saturating depth count and sticky error flags.
  // A new error takes priority over err_clr raised in the same cycle.
  always_comb begin
    depth_d = depth_q;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    unique case (move)
      MV_HOLD: begin
        depth_d = depth_q;
      end
      MV_PUSH: begin
        if (depth_q == DEPTH_MAX) begin
          ovf_evt = 1'b1;
        end else begin
          depth_d = depth_q + ONE;
        end
      end
      MV_POP: begin
        if (depth_q == '0) begin
          udf_evt = 1'b1;
          depth_d = '0;
        end else begin
          depth_d = depth_q - ONE;
        end
      end
      MV_POP2: begin
        if (depth_q < TWO) begin
          udf_evt = 1'b1;
          depth_d = '0;
        end else begin
          depth_d = depth_q - TWO;
        end
      end
      default: begin
        depth_d = depth_q;
      end
    endcase
    ovf_d = ovf_evt | (ovf_q & ~err_clr);
    udf_d = udf_evt | (udf_q & ~err_clr);
  end

  // State registers. Reset overrides every input and reloads every cell with FILL.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cells_q[i] <= FILL;
      end
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      for (int i = 0; i < DEPTH; i++) begin
        cells_q[i] <= cells_d[i];
      end
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign rd        = head_q;
  assign rd2       = cells_q[0];
  assign depth     = depth_q;
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DEPTH_MAX);
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
